slot_button_conditioner: RTL and testbench
==========================================

// Module: slot_button_conditioner
// PURPOSE
//  Input-side counterpart to the display path. It turns the raw, bouncy, asynchronous
//  start/stop push-buttons into clean one-clock pulses for the slot body.
//  Each button is synchronised, debounced and edge-detected.
//  Simultaneous stop presses are serialised: at most one stop pulse per cycle, none lost.
//  Sits between the board buttons and the start/stop[2:0] inputs of the slot machine top.
// PARAMETERS
//  N_STOP           3      number of reels / stop buttons
//  DEBOUNCE_CYCLES  20000  consecutive stable clock cycles required to accept a level change
//  CNT_W            15     debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  clock          in   1        system clock; all state on rising edge
//  reset          in   1        asynchronous, active-high; clears all state
//  btn_start_raw  in   1        raw start button, asynchronous to clock
//  btn_stop_raw   in   N_STOP   raw stop buttons, index 0 = left reel
//  start_pulse    out  1        one-cycle pulse per accepted start press
//  stop_pulse     out  N_STOP   one-hot (or zero) one-cycle pulse per accepted stop press
//  btn_level      out  N_STOP+1 debounced levels {stops, start}; bit 0 = start
//  stop_pending   out  1        high while any accepted stop press awaits issue
// BEHAVIOUR
//  Reset: all outputs 0; sync flops, debounce counters, levels and pending bits all 0.
//   Reset is honoured asynchronously at any point; in-flight presses are discarded.
//  Synchroniser: 2 flops per button. The raw value is inverted first when BTN_ACTIVE_LOW_EN is set.
//  Debounce, per button:
//   - cnt counts cycles where sync_out != level.
//   - cnt clears to 0 on any cycle where they are equal.
//   - When cnt == DEBOUNCE_CYCLES-1 and they still differ, level toggles on the next edge
//     and cnt clears.
//   - Glitches shorter than DEBOUNCE_CYCLES never change level.
//  Edge detect: press = level rises; release generates nothing.
//  Start: start_pulse is registered, high exactly 1 cycle, on the edge after start's level rises.
//   Latency from a clean raw press = 2 + DEBOUNCE_CYCLES + 1 edges.
//  Stop arbitration (registered):
//   - req = pending | stop_press
//   - grant = lowest set bit of req
//   - stop_pulse <= grant
//   - pending <= req & ~grant
//   - A lone stop press has the same latency as start.
//   - A second press of a bit already pending merges; it does not create an extra pulse.
//   - Simultaneous presses issue in index order, one per cycle.
//  stop_pending = |pending (registered value).
//  start and stop are independent: a start pulse may coincide with a stop pulse.
//  Counters saturate nowhere. Reaching DEBOUNCE_CYCLES-1 always resolves, so no overflow.
// CONFIGURATION
//  BTN_ACTIVE_LOW_EN:
//   - Defined: raw inputs are inverted before the synchroniser
//     (buttons pulled up, pressed = 0).
//   - Undefined: pressed = 1.
//   - Reset level of btn_level is 0 (released) in both cases.
// STRUCTURE
//  Shared package slot_pkg:
//   - N_STOP and reel index constants LEFT=0, MIDDLE=1, RIGHT=2
//   - default DEBOUNCE_CYCLES
//  Sub-module slot_debounce (one instance per button, via generate):
//   - 2-flop synchroniser, counter, level, rise pulse
//   - params DEBOUNCE_CYCLES and CNT_W
//  Top: N_STOP+1 instances of slot_debounce, the stop arbiter and pending register,
//   and the start output register.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1. Reset mid-press: assert reset while cnt=2 on stop[1] ->
//     all outputs 0 immediately; no pulse after release of reset.
//  2. Clean start press, held 20 cycles ->
//     btn_level[0] rises on edge 6 after raw rise; start_pulse=1 on edge 7 only.
//  3. Bounce: btn_stop_raw[0] toggles every 2 cycles for 12 cycles, then holds 1 ->
//     exactly one stop_pulse=3'b001; none during the bounce.
//  4. Glitch: btn_start_raw high for 3 cycles, then low -> btn_level and start_pulse stay 0.
//  5. Simultaneous stops 3'b111 rising on the same cycle ->
//     stop_pulse 001, 010, 100 on 3 consecutive cycles;
//     stop_pending = 1 for the first two of those cycles, then 0.
//  6. Start and stop[2] pressed together ->
//     start_pulse and stop_pulse=3'b100 in the same cycle;
//     release of either button generates no pulse.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared constants for the slot machine button path.
//   N_STOP                  : number of reels / stop buttons
//   reel_e                  : reel index names (LEFT = 0 is the leftmost reel)
//   DEFAULT_DEBOUNCE_CYCLES : stable cycles needed to accept a level change
//   DEFAULT_CNT_W           : debounce counter width (2**W > DEBOUNCE_CYCLES)
//   lowest_set()            : isolates the lowest set bit of a stop vector
package slot_pkg;

  localparam int unsigned N_STOP = 3;

  typedef enum int unsigned {
    LEFT   = 0,
    MIDDLE = 1,
    RIGHT  = 2
  } reel_e;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 20000;
  localparam int unsigned DEFAULT_CNT_W           = 15;

  // Two's-complement trick: v & -v keeps only the least significant set bit.
  function automatic logic [N_STOP-1:0] lowest_set(input logic [N_STOP-1:0] v);
    return v & (-v);
  endfunction

endpackage

// File: rtl/slot_button_conditioner_if.sv
// Button-side bus of the slot button conditioner.
//   btn_start_raw : raw start button (asynchronous)
//   btn_stop_raw  : raw stop buttons, index 0 = left reel
//   start_pulse   : one-cycle pulse per accepted start press
//   stop_pulse    : one-hot (or zero) pulse per accepted stop press
//   btn_level     : debounced levels {stops, start}, bit 0 = start
//   stop_pending  : accepted stop presses still waiting to be issued
// Modports: master = board/driver side, slave = conditioner side.
interface slot_button_conditioner_if;
  import slot_pkg::*;

  logic              btn_start_raw;
  logic [N_STOP-1:0] btn_stop_raw;
  logic              start_pulse;
  logic [N_STOP-1:0] stop_pulse;
  logic [N_STOP:0]   btn_level;
  logic              stop_pending;

  modport master (
    output btn_start_raw, btn_stop_raw,
    input  start_pulse, stop_pulse, btn_level, stop_pending
  );

  modport slave (
    input  btn_start_raw, btn_stop_raw,
    output start_pulse, stop_pulse, btn_level, stop_pending
  );

endinterface

// File: rtl/slot_debounce.sv
// Per-button conditioner: 2-flop synchroniser, debounce counter, level
// register and a registered press pulse that rises together with level.
//   clock, reset : system clock, asynchronous active-high reset
//   raw          : raw button input, asynchronous to clock
//   level        : debounced level (1 = pressed)
//   press        : one-cycle pulse on the edge where level goes 0 -> 1
// Config macro BTN_ACTIVE_LOW_EN: when defined, raw is inverted before the
// synchroniser (pulled-up buttons, pressed = 0).
module slot_debounce
  import slot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  logic             raw_in;
  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

`ifdef BTN_ACTIVE_LOW_EN
  assign raw_in = ~raw;
`else
  assign raw_in = raw;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync_1 <= raw_in;
      sync_2 <= sync_1;
      press  <= 1'b0;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // Disagreement held for DEBOUNCE_CYCLES cycles: accept the new level.
        cnt   <= '0;
        level <= ~level;
        press <= ~level;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/slot_button_conditioner.sv
// Turns raw start/stop push-buttons into clean one-clock pulses for the
// slot body. One slot_debounce per button; stop presses are serialised by a
// lowest-index-first arbiter with a pending register so none are lost.
//   clock : system clock, rising edge
//   reset : asynchronous active-high reset, clears all state
//   btn   : slot_button_conditioner_if.slave (raw buttons in, pulses out)
// Config macro BTN_ACTIVE_LOW_EN (handled inside slot_debounce).
module slot_button_conditioner
  import slot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input logic                       clock,
  input logic                       reset,
  slot_button_conditioner_if.slave  btn
);

  logic [N_STOP:0]   raw_all;
  logic [N_STOP:0]   level_all;
  logic [N_STOP:0]   press_all;
  logic [N_STOP-1:0] pending;
  logic [N_STOP-1:0] req;
  logic [N_STOP-1:0] grant;
  logic              start_q;
  logic [N_STOP-1:0] stop_q;

  // Bit 0 is start, bits N_STOP:1 are the stop buttons.
  assign raw_all = {btn.btn_stop_raw, btn.btn_start_raw};

  for (genvar i = 0; i < N_STOP + 1; i++) begin : g_btn
    slot_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clock (clock),
      .reset (reset),
      .raw   (raw_all[i]),
      .level (level_all[i]),
      .press (press_all[i])
    );
  end

  // A new press of an already-pending bit merges into the OR.
  always_comb begin
    req   = pending | press_all[N_STOP:1];
    grant = lowest_set(req);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      stop_q  <= '0;
      pending <= '0;
    end else begin
      start_q <= press_all[0];
      stop_q  <= grant;
      pending <= req & ~grant;
    end
  end

  assign btn.start_pulse  = start_q;
  assign btn.stop_pulse   = stop_q;
  assign btn.btn_level    = level_all;
  assign btn.stop_pending = |pending;

endmodule

// File: tb/tb_slot_button_conditioner.sv
module tb_slot_button_conditioner;
  import slot_pkg::*;

  localparam int D  = 4;
  localparam int NB = N_STOP + 1;
`ifdef BTN_ACTIVE_LOW_EN
  localparam bit AL = 1'b1;
`else
  localparam bit AL = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic press_start;
  logic [N_STOP-1:0] press_stop;

  slot_button_conditioner_if bus ();

  assign bus.btn_start_raw = press_start ^ AL;
  assign bus.btn_stop_raw  = press_stop ^ {N_STOP{AL}};

  slot_button_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .btn   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clock) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // A button's accepted level flips once its synchronised input (raw delayed
  // two clocks) has disagreed with the level for the last D samples.
  typedef struct {
    logic              start;
    logic [N_STOP-1:0] stop;
    logic [NB-1:0]     level;
    logic              pending;
  } exp_t;

  exp_t          expq[$];
  logic [NB-1:0] hist[$];
  logic [NB-1:0] m_level;
  logic [NB-1:0] m_press;
  bit            m_pend[N_STOP];
  bit            primed = 0;

  task automatic model_reset();
    hist.delete();
    repeat (D + 2) hist.push_back('0);
    m_level = '0;
    m_press = '0;
    for (int i = 0; i < N_STOP; i++) m_pend[i] = 0;
    expq.delete();
    primed = 0;
  endtask

  always @(posedge clock or posedge reset) begin : model
    exp_t e;
    logic [NB-1:0] new_press;
    bit found;
    bit all_differ;
    if (reset) begin
      model_reset();
    end else begin
      hist.push_back({press_stop, press_start});
      if (hist.size() > D + 2) void'(hist.pop_front());
      // outputs produced from presses accepted on the previous edge
      e.start = m_press[0];
      for (int i = 0; i < N_STOP; i++)
        if (m_press[i+1]) m_pend[i] = 1;
      e.stop = '0;
      found  = 0;
      for (int i = 0; i < N_STOP; i++) begin
        if (m_pend[i] && !found) begin
          e.stop[i] = 1'b1;
          m_pend[i] = 0;
          found     = 1;
        end
      end
      e.pending = 0;
      for (int i = 0; i < N_STOP; i++) if (m_pend[i]) e.pending = 1;
      new_press = '0;
      for (int b = 0; b < NB; b++) begin
        all_differ = 1;
        for (int j = 0; j < D; j++) if (hist[j][b] == m_level[b]) all_differ = 0;
        if (all_differ) begin
          m_level[b]   = ~m_level[b];
          new_press[b] = m_level[b];
        end
      end
      m_press = new_press;
      e.level = m_level;
      expq.push_back(e);
      primed = 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  typedef struct { int c; logic [N_STOP-1:0] v; logic p; } stop_ev_t;
  stop_ev_t stop_log[$];
  int       start_log[$];
  int       lvl0_rise[$];
  logic     prev_lvl0 = 1'b0;

  always @(negedge clock) begin : mon
    exp_t e;
    stop_ev_t s;
    if (reset || !primed) begin
      check("idle_start", 32'(bus.start_pulse), 0);
      check("idle_stop", 32'(bus.stop_pulse), 0);
      check("idle_level", 32'(bus.btn_level), 0);
      check("idle_pending", 32'(bus.stop_pending), 0);
      prev_lvl0 = 1'b0;
    end else if (expq.size() == 0) begin
      check("sb_underflow", 32'(expq.size()), 1);
    end else begin
      e = expq.pop_front();
      check("sb_start", 32'(bus.start_pulse), 32'(e.start));
      check("sb_stop", 32'(bus.stop_pulse), 32'(e.stop));
      check("sb_level", 32'(bus.btn_level), 32'(e.level));
      check("sb_pending", 32'(bus.stop_pending), 32'(e.pending));
      if (bus.start_pulse === 1'b1) start_log.push_back(cyc);
      if (bus.stop_pulse !== '0) begin
        s.c = cyc; s.v = bus.stop_pulse; s.p = bus.stop_pending;
        stop_log.push_back(s);
      end
      if (bus.btn_level[0] === 1'b1 && prev_lvl0 === 1'b0) lvl0_rise.push_back(cyc);
      prev_lvl0 = bus.btn_level[0];
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic clear_logs();
    stop_log.delete();
    start_log.delete();
    lvl0_rise.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_start"}, 32'(bus.start_pulse), 0);
    check({tag, "_stop"}, 32'(bus.stop_pulse), 0);
    check({tag, "_level"}, 32'(bus.btn_level), 0);
    check({tag, "_pending"}, 32'(bus.stop_pending), 0);
  endtask

  int c0;

  initial begin
    press_start = 1'b0;
    press_stop  = '0;
    #1 reset = 1'b1;
    #1 check_zero("reset");
    tick(3);
    reset = 1'b0;
    tick(5);

    // 1. reset while stop[1] is mid-debounce (cnt = 2)
    clear_logs();
    press_stop = 3'b010;
    tick(4);
    reset = 1'b1;
    #1 check_zero("t1_rst");
    press_stop = '0;
    tick(2);
    reset = 1'b0;
    tick(12);
    check("t1_no_stop", 32'(stop_log.size()), 0);

    // 2. clean start press held 20 cycles
    clear_logs();
    c0 = cyc;
    press_start = 1'b1;
    tick(20);
    press_start = 1'b0;
    tick(10);
    check("t2_n_start", 32'(start_log.size()), 1);
    check("t2_n_rise", 32'(lvl0_rise.size()), 1);
    if (start_log.size() == 1) check("t2_pulse_lat", 32'(start_log[0] - c0), 7);
    if (lvl0_rise.size() == 1) check("t2_level_lat", 32'(lvl0_rise[0] - c0), 6);

    // 3. bouncing stop[0], then held
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      press_stop[0] = (i % 2 == 0);
      tick(2);
    end
    check("t3_bounce_quiet", 32'(stop_log.size()), 0);
    press_stop[0] = 1'b1;
    tick(15);
    check("t3_n_stop", 32'(stop_log.size()), 1);
    if (stop_log.size() == 1) check("t3_value", 32'(stop_log[0].v), 32'b001);
    press_stop = '0;
    tick(10);

    // 4. start glitch shorter than the debounce window
    clear_logs();
    press_start = 1'b1;
    tick(3);
    press_start = 1'b0;
    tick(12);
    check("t4_n_start", 32'(start_log.size()), 0);
    check("t4_n_rise", 32'(lvl0_rise.size()), 0);

    // 5. all three stops together
    clear_logs();
    c0 = cyc;
    press_stop = 3'b111;
    tick(14);
    check("t5_n_stop", 32'(stop_log.size()), 3);
    if (stop_log.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("t5_value", 32'(stop_log[i].v), 32'(1 << i));
        check("t5_cycle", 32'(stop_log[i].c - c0), 32'(7 + i));
        check("t5_pending", 32'(stop_log[i].p), (i < 2) ? 1 : 0);
      end
    end
    press_stop = '0;
    tick(10);
    check("t5_release", 32'(stop_log.size()), 3);

    // 6. start and stop[2] together
    clear_logs();
    press_start = 1'b1;
    press_stop  = 3'b100;
    tick(12);
    check("t6_n_start", 32'(start_log.size()), 1);
    check("t6_n_stop", 32'(stop_log.size()), 1);
    if (start_log.size() == 1 && stop_log.size() == 1) begin
      check("t6_same_cycle", 32'(stop_log[0].c), 32'(start_log[0]));
      check("t6_value", 32'(stop_log[0].v), 32'b100);
    end
    press_start = 1'b0;
    tick(8);
    press_stop = '0;
    tick(8);
    check("t6_rel_start", 32'(start_log.size()), 1);
    check("t6_rel_stop", 32'(stop_log.size()), 1);

    // random phase, checked cycle by cycle through the scoreboard
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) press_start = ~press_start;
      for (int b = 0; b < N_STOP; b++)
        if ($urandom_range(0, 5) == 0) press_stop[b] = ~press_stop[b];
      if (i == 200) reset = 1'b1;
      if (i == 203) reset = 1'b0;
      tick(1);
    end

    // reset with all levels high clears them immediately
    press_start = 1'b1;
    press_stop  = 3'b111;
    tick(12);
    check("hold_levels", 32'(bus.btn_level), 32'hF);
    reset = 1'b1;
    #1 check_zero("t_async_rst");
    press_start = 1'b0;
    press_stop  = '0;
    tick(2);
    reset = 1'b0;
    tick(10);
    @(negedge clock);
    #1 check("sb_drained", 32'(expq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
